// File: rtl/bs_chain_loader.sv
// bs_chain_loader: loads NUM_CHAINS parallel serial configuration chains.
// Each accepted input beat carries WORD_W bits per chain. The bits are
// shifted out MSB-first on ccff_head while ccff_en is high, until cfg_len
// bits per chain have been sent. The low bits of a partial final word are
// dropped. The running XOR of ccff_tail is kept per chain.
//
// Ports
//   clk, reset   : sole clock; synchronous active-high reset
//   start        : begin a load (only honoured in IDLE)
//   cfg_len      : bits to shift per chain, latched on an accepted start
//   s_valid/s_ready/s_data : input beat handshake, chain c at [c*WORD_W +: WORD_W]
//   ccff_head    : serial config bit per chain, zero when ccff_en is low
//   ccff_en      : chain shift enable
//   ccff_tail    : serial tail per chain, folded into tail_parity while shifting
//   busy         : load in progress (FETCH or SHIFT)
//   done         : one-cycle completion pulse
//   config_done  : completion level, cleared by the next accepted start
//   tail_parity  : running XOR of ccff_tail per chain
module bs_chain_loader #(
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_W-1:0]             cfg_len,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_CHAINS*WORD_W-1:0] s_data,
  output logic [NUM_CHAINS-1:0]        ccff_head,
  output logic                         ccff_en,
  input  logic [NUM_CHAINS-1:0]        ccff_tail,
  output logic                         busy,
  output logic                         done,
  output logic                         config_done,
  output logic [NUM_CHAINS-1:0]        tail_parity
);

  localparam int unsigned DATA_W = NUM_CHAINS * WORD_W;
  localparam int unsigned CNT_W  = $clog2(WORD_W + 1);
  localparam int unsigned CMP_W  = (LEN_W > CNT_W) ? LEN_W : CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       sreg_q, sreg_d;
  logic [NUM_CHAINS-1:0]   parity_d;
  logic [NUM_CHAINS-1:0]   head_d;
  logic                    cfg_done_d;

  // Next-state and datapath: outputs are registered from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    parity_d   = tail_parity;
    cfg_done_d = config_done;
    head_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          parity_d = '0;
          if (cfg_len != '0) begin
            rem_d      = cfg_len;
            cfg_done_d = 1'b0;
            state_d    = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end

      FETCH: begin
        if (s_valid) begin
          sreg_d  = s_data;
          // Word count = min(WORD_W, remaining); compared in a common width.
          cnt_d   = (CMP_W'(rem_q) >= CMP_W'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(rem_q);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
          sreg_d[c*WORD_W +: WORD_W] = sreg_q[c*WORD_W +: WORD_W] << 1;
        end
        parity_d = tail_parity ^ ccff_tail;
        rem_d    = rem_q - LEN_W'(1);
        cnt_d    = cnt_q - CNT_W'(1);
        // Finishing the load wins over fetching, which also drops the unused
        // low bits of a partial final word.
        if (rem_q == LEN_W'(1)) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = FETCH;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      cfg_done_d = 1'b1;
    end

    // Head bit presented next cycle is the MSB of each chain's next register.
    if (state_d == SHIFT) begin
      for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
        head_d[c] = sreg_d[c*WORD_W + WORD_W - 1];
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      sreg_q      <= '0;
      s_ready     <= 1'b0;
      ccff_en     <= 1'b0;
      ccff_head   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      config_done <= 1'b0;
      tail_parity <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      s_ready     <= (state_d == FETCH);
      ccff_en     <= (state_d == SHIFT);
      ccff_head   <= head_d;
      busy        <= (state_d == FETCH) || (state_d == SHIFT);
      done        <= (state_d == DONE);
      config_done <= cfg_done_d;
      tail_parity <= parity_d;
    end
  end

endmodule

// File: tb/tb_bs_chain_loader.sv
// Randomized scoreboard bench for bs_chain_loader (2 chains, 8-bit words,
// 8-bit length field). The driver pushes the expected per-cycle head bits,
// derived directly from the beat contents and cfg_len; the monitor pops and
// compares whenever ccff_en is high and checks completion state on done.
module tb_bs_chain_loader;

  localparam int unsigned NC = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned LW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [LW-1:0]   cfg_len;
  logic            s_valid;
  logic            s_ready;
  logic [NC*W-1:0] s_data;
  logic [NC-1:0]   ccff_head;
  logic            ccff_en;
  logic [NC-1:0]   ccff_tail;
  logic            busy;
  logic            done;
  logic            config_done;
  logic [NC-1:0]   tail_parity;

  bs_chain_loader #(.NUM_CHAINS(NC), .WORD_W(W), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .config_done(config_done),
    .tail_parity(tail_parity)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [15:0]  beats[$];
  logic [NC-1:0] exp_q[$];
  logic [NC-1:0] tail_pat[$];
  logic [NC-1:0] par_model = '0;
  logic [NC-1:0] e;
  int           beats_seen = 0;
  int           exp_beats = 0;
  bit           start_real = 1'b0;
  bit           expect_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (start_real) par_model = '0;
      if (ccff_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ccff_en", 64'(ccff_en), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ccff_head", 64'(ccff_head), 64'(e));
        end
        chk("busy_in_shift", 64'(busy), 64'(1));
        par_model = par_model ^ ccff_tail;
      end else begin
        chk("head_zero_when_idle", 64'(ccff_head), 64'(0));
      end
      if (s_valid && s_ready) beats_seen++;
      if (done) begin
        chk("done_expected", 64'(expect_done), 64'(1));
        chk("bits_remaining", 64'(exp_q.size()), 64'(0));
        chk("config_done_at_done", 64'(config_done), 64'(1));
        chk("tail_parity_at_done", 64'(tail_parity), 64'(par_model));
        chk("beats_consumed", 64'(beats_seen), 64'(exp_beats));
      end
    end
  end

  // Tail stimulus: a queued pattern during shifting, random otherwise.
  always @(posedge clk) begin
    #1;
    if (ccff_en && tail_pat.size() > 0) ccff_tail = tail_pat.pop_front();
    else ccff_tail = NC'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load. Beats come from 'beats' (random if empty).
  task automatic run_load(input int len, input int stall_beat, input int stall_cyc,
                          input bit poke_start, input bit check_lat);
    int nb;
    int k;
    longint t0;
    logic [15:0] bw;
    logic [NC-1:0] v;
    nb = (len + W - 1) / W;
    if (beats.size() == 0)
      for (int b = 0; b < nb; b++) beats.push_back(16'($urandom));
    for (int i = 0; i < len; i++) begin
      bw = beats[i / W];
      for (int c = 0; c < NC; c++) v[c] = bw[c*W + W - 1 - (i % W)];
      exp_q.push_back(v);
    end
    exp_beats   = nb;
    beats_seen  = 0;
    expect_done = 1'b1;
    if (len == 0) s_valid = 1'b1;
    cfg_len    = LW'(len);
    start      = 1'b1;
    start_real = 1'b1;
    tick();
    start      = 1'b0;
    start_real = 1'b0;
    t0 = $time;
    chk("parity_cleared_on_start", 64'(tail_parity), 64'(0));
    chk("config_done_after_start", 64'(config_done), 64'(len == 0));
    for (int b = 0; b < nb; b++) begin
      if (b == stall_beat) begin
        k = 0;
        while (!s_ready && k < 300) begin tick(); k++; end
        for (int s = 0; s < stall_cyc; s++) begin
          chk("stall_ccff_en", 64'(ccff_en), 64'(0));
          chk("stall_s_ready", 64'(s_ready), 64'(1));
          tick();
        end
      end
      s_data  = beats[b];
      s_valid = 1'b1;
      k = 0;
      while (!s_ready && k < 300) begin tick(); k++; end
      if (!s_ready) chk("beat_timeout", 64'(s_ready), 64'(1));
      tick();
      s_valid = 1'b0;
      s_data  = 16'($urandom);
      if (poke_start && b == 0) begin
        start   = 1'b1;
        cfg_len = LW'(3);
        tick();
        start   = 1'b0;
      end
    end
    k = 0;
    while (!done && k < 1000) begin tick(); k++; end
    chk("done_seen", 64'(done), 64'(1));
    s_valid = 1'b0;
    if (check_lat) chk("done_latency", 64'(($time - t0) / 10), 64'(nb + len));
    if (poke_start) begin
      start   = 1'b1;
      cfg_len = LW'(5);
    end
    tick();
    start       = 1'b0;
    expect_done = 1'b0;
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("config_done_held", 64'(config_done), 64'(1));
    tick();
    chk("idle_after_done", 64'({busy, s_ready, ccff_en}), 64'(0));
    beats.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    chk({tag, "_ccff_en"}, 64'(ccff_en), 64'(0));
    chk({tag, "_ccff_head"}, 64'(ccff_head), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_config_done"}, 64'(config_done), 64'(0));
    chk({tag, "_tail_parity"}, 64'(tail_parity), 64'(0));
  endtask

  logic [15:0] saved[$];
  int k0;

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; s_valid = 1'b0;
    s_data = '0; ccff_tail = '0;
    repeat (3) tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();

    // Single word 8'hA5 on chain 0.
    beats.push_back(16'h00A5);
    run_load(8, -1, 0, 1'b0, 1'b1);

    // Two beats with a partial final word.
    beats.push_back(16'hF00F);
    beats.push_back(16'h3CC3);
    run_load(12, -1, 0, 1'b0, 1'b1);

    // Stalled second beat, then the same data unstalled.
    for (int b = 0; b < 2; b++) saved.push_back(16'($urandom));
    beats = saved;
    run_load(16, 1, 5, 1'b0, 1'b0);
    beats = saved;
    run_load(16, -1, 0, 1'b0, 1'b1);

    // Zero-length load.
    run_load(0, -1, 0, 1'b0, 1'b1);

    // Tail parity pattern 1,1,0,1 on both chains.
    tail_pat = '{2'b11, 2'b11, 2'b00, 2'b11};
    run_load(4, -1, 0, 1'b0, 1'b1);
    chk("tail_parity_pattern", 64'(tail_parity), 64'(2'b11));

    // Start pulses while busy and in DONE are ignored.
    run_load(20, -1, 0, 1'b1, 1'b1);

    // Reset in the third shift cycle of an 8-bit load.
    beats.push_back(16'($urandom));
    begin
      logic [15:0] bw;
      logic [NC-1:0] v;
      bw = beats[0];
      for (int i = 0; i < 8; i++) begin
        for (int c = 0; c < NC; c++) v[c] = bw[c*W + 7 - i];
        exp_q.push_back(v);
      end
    end
    expect_done = 1'b0;
    cfg_len = LW'(8);
    start = 1'b1;
    start_real = 1'b1;
    tick();
    start = 1'b0;
    start_real = 1'b0;
    s_data = beats[0];
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    k0 = 0;
    while (!ccff_en && k0 < 20) begin tick(); k0++; end
    chk("abort_in_shift", 64'(ccff_en), 64'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("abort");
    reset = 1'b0;
    exp_q.delete();
    beats.delete();
    par_model = '0;
    repeat (4) tick();
    chk("no_done_after_abort", 64'(done), 64'(0));
    run_load(8, -1, 0, 1'b0, 1'b1);

    // Maximum length: no wrap of the remaining count.
    run_load(255, -1, 0, 1'b0, 1'b1);

    // Random loads with random stalls.
    for (int n = 0; n < 15; n++) begin
      int len;
      int sb;
      len = int'($urandom_range(1, 40));
      sb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (len - 1) / W)) : -1;
      run_load(len, sb, int'($urandom_range(1, 6)), 1'b0, sb < 0);
      repeat (int'($urandom_range(0, 3))) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
